// File: rtl/core_pkg.sv
// Shared core definitions: load/store funct3 encodings, memory-stage FSM states,
// byte-enable patterns and access-size helpers.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {MS_IDLE, MS_REQ, MS_WAIT, MS_FIN} ms_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // Low two funct3 bits carry the size; unused codes fall back to a word access.
  function automatic size_t f3_size(input logic [1:0] sz_bits);
    case (sz_bits)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz_bits, input logic [1:0] lo);
    case (f3_size(sz_bits))
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data and
// lane-extracted, sign/zero-extended load data.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  size_t       size;
  logic        uns;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign size = f3_size(funct3[1:0]);
  assign uns  = (funct3 == F3_BU) || (funct3 == F3_HU);

  // Halves only look at addr[1] and words at lane 0, so an unaligned
  // address quietly rounds down when the trap is not built in.
  always_comb begin
    be       = BE_WORD;
    wdata    = store_data;
    load_ext = rdata;
    lane_b   = rdata[7:0];
    lane_h   = rdata[15:0];
    case (size)
      SZ_BYTE: begin
        be       = BE_BYTE << addr_lo;
        wdata    = {4{store_data[7:0]}};
        lane_b   = 8'(rdata >> {addr_lo, 3'b000});
        load_ext = uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be       = addr_lo[1] ? (BE_HALF << 2) : BE_HALF;
        wdata    = {2{store_data[15:0]}};
        lane_h   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_ext = uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/gnt/rvalid handshake with data memory, load extension,
// timeout abort. Optional misalignment trap enabled by MEM_MISALIGN_TRAP_EN.
module mem_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  ms_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc_addr, acc_wdata, load_ext, lane_wdata;
  logic [2:0]       acc_f3;
  logic             acc_load, mis_q, mis_now, timeout_hit;
  logic [3:0]       lane_be;

  lsu_align u_align (
    .funct3     (acc_f3),
    .addr_lo    (acc_addr[1:0]),
    .store_data (acc_wdata),
    .rdata      (mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_ext   (load_ext)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_now = (is_load || is_store) && is_misaligned(funct3[1:0], addr[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  // cnt holds the number of completed cycles in the current REQ/WAIT visit.
  assign timeout_hit = (TIMEOUT > 0) && (cnt == TO_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      MS_IDLE: begin
        if (start) state_nx = ((is_load || is_store) && !mis_now) ? MS_REQ : MS_FIN;
      end
      MS_REQ: begin
        if (mem_gnt)          state_nx = acc_load ? MS_WAIT : MS_FIN;
        else if (timeout_hit) state_nx = MS_FIN;
      end
      MS_WAIT: begin
        if (mem_rvalid || timeout_hit) state_nx = MS_FIN;
      end
      default: state_nx = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MS_IDLE;
      cnt       <= '0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_f3    <= '0;
      acc_load  <= 1'b0;
      load_data <= '0;
      bus_err   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (state == MS_REQ || state == MS_WAIT) cnt <= cnt + 1'b1;
      case (state)
        MS_IDLE: begin
          if (start) begin
            acc_addr  <= addr;
            acc_f3    <= funct3;
            acc_wdata <= store_data;
            acc_load  <= is_load;
            load_data <= '0;
            bus_err   <= 1'b0;
            mis_q     <= mis_now;
          end
        end
        MS_REQ: if (!mem_gnt && timeout_hit) bus_err <= 1'b1;
        MS_WAIT: begin
          if (mem_rvalid)       load_data <= load_ext;
          else if (timeout_hit) bus_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != MS_IDLE) || start;
  assign done       = (state == MS_FIN);
  assign misaligned = mis_q;
  assign mem_req    = (state == MS_REQ);
  assign mem_we     = mem_req && !acc_load;
  assign mem_addr   = mem_req ? {acc_addr[31:2], 2'b00} : '0;
  assign mem_be     = mem_req ? lane_be : '0;
  assign mem_wdata  = mem_we ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences for timeout/reset,
// and randomized accesses against a lane/size arithmetic model.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic        busy, done, bus_err, misaligned, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .bus_err(bus_err), .misaligned(misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    int          gd, rvd;
    bit          poke;
    int          e_req_cyc;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_load;
    logic        e_err, e_mis;
    int          e_lat;
  } vec_t;

  typedef struct {
    int          lat, req_cyc;
    logic [31:0] addr, wdata, load;
    logic [3:0]  be;
    logic        we, err, mis, busy0;
    bit          unstable;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t vt(input string name, input logic ld, st, input logic [2:0] f3,
                              input logic [31:0] a, wd, rd, input int gd, rvd, input bit poke,
                              input int rc, input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic ewe, input logic [31:0] eld,
                              input logic eerr, emis, input int elat);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd;
    v.gd = gd; v.rvd = rvd; v.poke = poke; v.e_req_cyc = rc; v.e_addr = ea; v.e_be = ebe;
    v.e_wdata = ewd; v.e_we = ewe; v.e_load = eld; v.e_err = eerr; v.e_mis = emis; v.e_lat = elat;
    return v;
  endfunction

  // Reference: derive everything from access size, lane offset and plain arithmetic.
  function automatic vec_t model(input logic ld, st, input logic [2:0] f3,
                                 input logic [31:0] a, wd, rd, input int gd, rvd);
    vec_t   v;
    int     n, off;
    longint val, mask;
    bit     mis, go;
    logic [31:0] rep;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (ld || st) && ((a % n) != 0);
`else
    mis = 1'b0;
`endif
    go   = (ld || st) && !mis;
    off  = (n == 4) ? 0 : (n == 2) ? int'(a[1]) * 2 : int'(a[1:0]);
    mask = (longint'(1) << (8 * n)) - 1;
    val  = (longint'(rd) >> (8 * off)) & mask;
    if (!f3[2] && n < 4 && val[8*n-1]) val = val - (longint'(1) << (8 * n));
    for (int i = 0; i < 4; i++) rep[8*i +: 8] = wd[8*(i % n) +: 8];
    v = vt("rand", ld, st, f3, a, wd, rd, gd, rvd, 1'b0,
           go ? gd + 1 : 0, {a[31:2], 2'b00}, 4'((((1 << n) - 1) << off)),
           (go && !ld) ? rep : 32'h0, go && !ld, (go && ld) ? val[31:0] : 32'h0,
           1'b0, mis, !go ? 1 : (ld ? 2 + gd + rvd : 2 + gd));
    return v;
  endfunction

  task automatic access(input vec_t v, output obs_t o);
    int gcnt, rcnt;
    bit granted, fin;
    o.lat = 0; o.req_cyc = 0; o.unstable = 0; o.addr = '0; o.wdata = '0; o.be = '0;
    o.we = 1'b0; o.load = '0; o.err = 1'b0; o.mis = 1'b0;
    gcnt = 0; rcnt = 0; granted = 0; fin = 0;
    @(negedge clk);
    start = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3; addr = v.a; store_data = v.wd;
    #1 o.busy0 = busy;
    @(negedge clk);
    for (int c = 1; c <= 40 && !fin; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      is_load = 1'b0; is_store = 1'b0; funct3 = 3'b111;
      addr = 32'hFFFF_FFFF; store_data = 32'h0BAD_0BAD;
      start = (v.poke && c == 1);
      if (start) is_load = 1'b1;
      #1;
      if (done) begin
        fin = 1; o.lat = c; o.load = load_data; o.err = bus_err; o.mis = misaligned;
      end else if (mem_req) begin
        o.req_cyc++;
        if (o.req_cyc == 1) begin
          o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
        end else if (mem_addr !== o.addr || mem_be !== o.be || mem_wdata !== o.wdata || mem_we !== o.we)
          o.unstable = 1;
        if (!granted && gcnt == v.gd) begin mem_gnt = 1'b1; granted = 1; end
        else gcnt++;
      end else if (granted) begin
        rcnt++;
        if (rcnt == v.rvd) begin mem_rvalid = 1'b1; mem_rdata = v.rd; end
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; start = 1'b0; is_load = 1'b0;
  endtask

  task automatic run_and_check(input vec_t v);
    obs_t o;
    access(v, o);
    chk({v.name, ".busy_start"}, 32'(o.busy0), 32'd1);
    chk({v.name, ".latency"}, 32'(o.lat), 32'(v.e_lat));
    chk({v.name, ".req_cycles"}, 32'(o.req_cyc), 32'(v.e_req_cyc));
    if (v.e_req_cyc > 0) begin
      chk({v.name, ".mem_addr"}, o.addr, v.e_addr);
      chk({v.name, ".mem_be"}, 32'(o.be), 32'(v.e_be));
      chk({v.name, ".mem_wdata"}, o.wdata, v.e_wdata);
      chk({v.name, ".mem_we"}, 32'(o.we), 32'(v.e_we));
      chk({v.name, ".req_stable"}, 32'(o.unstable), 32'd0);
    end
    chk({v.name, ".load_data"}, o.load, v.e_load);
    chk({v.name, ".bus_err"}, 32'(o.err), 32'(v.e_err));
    chk({v.name, ".misaligned"}, 32'(o.mis), 32'(v.e_mis));
    chk({v.name, ".after_done"}, {30'h0, done, busy}, 32'h0);
    chk({v.name, ".load_held"}, load_data, v.e_load);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic ld, st;
    logic [2:0] f3;
    int op;

    tbl.push_back(vt("SW", 0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h104, 4'hF, 32'hDEADBEEF, 1, 0, 0, 0, 2));
    tbl.push_back(vt("SB", 0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 3, 0, 1, 4, 32'h200, 4'h8, 32'hA5A5A5A5, 1, 0, 0, 0, 5));
    tbl.push_back(vt("LB", 1, 0, 3'b000, 32'h102, 0, 32'h12F45678, 0, 2, 0, 1, 32'h100, 4'h4, 0, 0, 32'hFFFFFFF4, 0, 0, 4));
    tbl.push_back(vt("LBU", 1, 0, 3'b100, 32'h102, 0, 32'h12F45678, 0, 2, 0, 1, 32'h100, 4'h4, 0, 0, 32'h000000F4, 0, 0, 4));
    tbl.push_back(vt("LH", 1, 0, 3'b001, 32'h102, 0, 32'h80017FFF, 1, 1, 0, 2, 32'h100, 4'hC, 0, 0, 32'hFFFF8001, 0, 0, 4));
    tbl.push_back(vt("LHU", 1, 0, 3'b101, 32'h102, 0, 32'h80017FFF, 0, 1, 0, 1, 32'h100, 4'hC, 0, 0, 32'h00008001, 0, 0, 3));
    tbl.push_back(vt("LW", 1, 0, 3'b010, 32'h100, 0, 32'h13579BDF, 0, 1, 0, 1, 32'h100, 4'hF, 0, 0, 32'h13579BDF, 0, 0, 3));
    tbl.push_back(vt("SH", 0, 1, 3'b001, 32'h106, 32'h1234ABCD, 0, 1, 0, 0, 2, 32'h104, 4'hC, 32'hABCDABCD, 1, 0, 0, 0, 3));
    tbl.push_back(vt("LBpos", 1, 0, 3'b000, 32'h001, 0, 32'h00007F00, 0, 1, 0, 1, 32'h0, 4'h2, 0, 0, 32'h0000007F, 0, 0, 3));
    tbl.push_back(vt("NONE", 0, 0, 3'b010, 32'h500, 32'h55555555, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(vt("BOTH", 1, 1, 3'b010, 32'h10C, 32'h11111111, 32'hCAFEF00D, 0, 1, 0, 1, 32'h10C, 4'hF, 0, 0, 32'hCAFEF00D, 0, 0, 3));
    tbl.push_back(vt("TO_WAIT", 1, 0, 3'b010, 32'h300, 0, 32'h12345678, 0, 99, 0, 1, 32'h300, 4'hF, 0, 0, 0, 1, 0, 6));
`ifdef MEM_MISALIGN_TRAP_EN
    tbl.push_back(vt("LW_mis", 1, 0, 3'b010, 32'h101, 0, 32'h89ABCDEF, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(vt("SH_mis", 0, 1, 3'b001, 32'h103, 32'h0000BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
`else
    tbl.push_back(vt("LW_mis", 1, 0, 3'b010, 32'h101, 0, 32'h89ABCDEF, 0, 1, 0, 1, 32'h100, 4'hF, 0, 0, 32'h89ABCDEF, 0, 0, 3));
    tbl.push_back(vt("SH_mis", 0, 1, 3'b001, 32'h103, 32'h0000BEEF, 0, 0, 0, 0, 1, 32'h100, 4'hC, 32'hBEEFBEEF, 1, 0, 0, 0, 2));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.ctrl", {26'h0, busy, done, bus_err, misaligned, mem_req, mem_we}, 32'h0);
    chk("reset.load_data", load_data, 32'h0);
    chk("reset.mem_addr", mem_addr, 32'h0);
    chk("reset.mem_be", 32'(mem_be), 32'h0);
    chk("reset.mem_wdata", mem_wdata, 32'h0);
    rst = 1'b1;

    foreach (tbl[i]) run_and_check(tbl[i]);

    // Request timeout, then a stray late response must be ignored
    run_and_check(vt("TO_REQ", 1, 0, 3'b010, 32'h200, 0, 0, 99, 1, 0, 4, 32'h200, 4'hF, 0, 0, 0, 1, 0, 5));
    @(negedge clk);
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk("late.ctrl", {29'h0, done, busy, mem_req}, 32'h0);
    chk("late.load_data", load_data, 32'h0);
    @(negedge clk);
    chk("late.done2", 32'(done), 32'h0);

    // Asynchronous reset in the middle of a request
    start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    start = 1'b0; is_load = 1'b0;
    chk("rst_mid.req_before", 32'(mem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.req", 32'(mem_req), 32'h0);
    chk("rst_mid.busy_addr", {mem_addr[31:1], busy}, 32'h0);
    chk("rst_mid.bus_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.idle", {30'h0, done, busy}, 32'h0);
    run_and_check(tbl[0]);

    // Randomized accesses against the model
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      op = $urandom_range(0, 9);
      ld = (op < 5) || (op == 9);
      st = (op >= 5 && op < 8 && !f3[2]) || (op == 9);
      v = model(ld, st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(1, 3));
      run_and_check(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage, directly downstream of the execute stage in the non-pipelined core.
- Consumes the ALU result as the effective address and the propagated second-register value as store data.
- Runs a request/grant/response handshake with the data memory and returns load data, sign- or zero-extended.
- Drives `busy` so the core controller holds the PC and writeback until the access completes.

Parameters:
- TIMEOUT, 16, max cycles waiting in REQ or WAIT before aborting with `bus_err`; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset
- start  in  1  one-cycle pulse: EX result valid, begin access
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- funct3  in  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- addr  in  32  effective address (ALU result)
- store_data  in  32  second register value
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, held until next `start`
- bus_err  out  1  timeout abort; valid with `done`
- misaligned  out  1  misaligned access detected; valid with `done`
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word address; bits [1:0] always 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- Interface (already decided): one clock, `clk`; `rst` is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, FIN.
- IDLE:
  - `start` with `is_load` or `is_store` latches addr, funct3, store_data and direction, clears `load_data`/flags, then goes to REQ.
  - `start` with neither goes to FIN; `load_data` = 0, no memory traffic.
  - `start` with both set is treated as a load.
  - `start` outside IDLE is ignored.
- REQ:
  - `mem_req` = 1 and all `mem_*` outputs held stable until `mem_gnt`.
  - On `gnt`: store goes to FIN; load goes to WAIT.
- WAIT:
  - On `mem_rvalid`: extract the lane, extend, register into `load_data`, go to FIN.
  - `mem_rvalid` in the same cycle as `gnt` is not allowed; responses arrive at least one cycle after `gnt`.
- FIN: `done` = 1 for exactly one cycle, then IDLE.
- `busy` = 1 in REQ, WAIT and FIN, and combinationally in IDLE while `start` is high.
- Minimum latency, counted from the `start` cycle with zero-wait memory:
  - store: `done` at cycle +2;
  - load: `done` at cycle +3.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << (addr[1]*2)
  - word: 1111
  - `mem_wdata` replicates the low byte/half into every lane.
- Load extraction: select lane by addr[1:0]; LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Timeout (TIMEOUT > 0):
  - Counter clears on entry to REQ and to WAIT and increments each cycle spent there.
  - Reaching TIMEOUT drops `mem_req`, goes to FIN with `bus_err` = 1 and `load_data` = 0.
  - A late `rvalid`/`gnt` in IDLE is ignored.
- Reset mid-access: immediate return to IDLE and `mem_req` drops asynchronously; the memory side must tolerate the abandoned request.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: half access with addr[0] = 1, or word access with addr[1:0] != 0, issues no memory request; goes IDLE -> FIN with `misaligned` = 1 and `load_data` = 0.
- Undefined:
  - `misaligned` is tied to 0.
  - Low address bits are ignored for the access size: halves use addr[1], words use lane 0.
  - The access proceeds normally.

Decomposition:
- Shared package `core_pkg`:
  - funct3 size/sign encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state enum (MS_IDLE, MS_REQ, MS_WAIT, MS_FIN);
  - byte-enable constants.
- One natural sub-module: `lsu_align`, combinational. It produces `mem_be`, `mem_wdata` and the extended load value from funct3, addr[1:0] and the raw data.

Test Plan:
- SW: addr 0x104, data 0xDEADBEEF, gnt in first REQ cycle -> mem_addr 0x104, be 1111, wdata 0xDEADBEEF, `done` at start+2.
- SB: addr 0x203, data 0x000000A5, gnt after 3 cycles -> be 1000, wdata 0xA5A5A5A5, req and outputs stable during the stall.
- LB / LBU: addr 0x102, rdata 0x12F45678, rvalid 2 cycles after gnt -> LB gives 0xFFFFFFF4, LBU gives 0x000000F4.
- LH: addr 0x102, rdata 0x80017FFF -> load_data 0xFFFF8001; LHU gives 0x00008001.
- Timeout: TIMEOUT = 4, load, gnt never asserted -> `mem_req` high 4 cycles, `done` with `bus_err` = 1, load_data 0; an rvalid two cycles later is ignored.
- MEM_MISALIGN_TRAP_EN defined, LW at 0x101 -> no `mem_req`, `done` with `misaligned` = 1. Undefined -> request to 0x100 with be 1111.
